// File: rtl/mult_arbiter.sv
// Time-shared shift-add multiplier serving two requesters through a round-robin
// arbiter; operands are captured at grant and the product is returned with a done pulse.
module mult_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic [WIDTH-1:0]     a0,
  input  logic [WIDTH-1:0]     b0,
  input  logic                 req1,
  input  logic [WIDTH-1:0]     a1,
  input  logic [WIDTH-1:0]     b1,
  output logic                 grant0,
  output logic                 grant1,
  output logic                 done0,
  output logic                 done1,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    TEST,
    ADD,
    SHIFT,
    DONE
  } state_t;

  state_t             state, state_next;
  logic [2*WIDTH:0]   acc, acc_next;
  logic [CW-1:0]      count, count_next;
  logic [WIDTH-1:0]   op_a, op_a_next;
  logic [WIDTH-1:0]   op_b, op_b_next;
  logic               owner, owner_next;
  logic               last_served, last_served_next;
  logic               grant0_next, grant1_next;
  logic               done0_next, done1_next;
  logic [2*WIDTH-1:0] product_next;
  logic               winner;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      count       <= '0;
      op_a        <= '0;
      op_b        <= '0;
      owner       <= 1'b0;
      last_served <= 1'b1;
      grant0      <= 1'b0;
      grant1      <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      product     <= '0;
    end else begin
      state       <= state_next;
      acc         <= acc_next;
      count       <= count_next;
      op_a        <= op_a_next;
      op_b        <= op_b_next;
      owner       <= owner_next;
      last_served <= last_served_next;
      grant0      <= grant0_next;
      grant1      <= grant1_next;
      done0       <= done0_next;
      done1       <= done1_next;
      product     <= product_next;
    end
  end

  // With both requests pending, whoever was not served last wins.
  always_comb begin
    if (req0 && req1) begin
      winner = ~last_served;
    end else begin
      winner = req1;
    end
  end

  always_comb begin
    state_next       = state;
    acc_next         = acc;
    count_next       = count;
    op_a_next        = op_a;
    op_b_next        = op_b;
    owner_next       = owner;
    last_served_next = last_served;
    grant0_next      = 1'b0;
    grant1_next      = 1'b0;
    done0_next       = 1'b0;
    done1_next       = 1'b0;
    product_next     = product;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          owner_next       = winner;
          last_served_next = winner;
          op_a_next        = winner ? a1 : a0;
          op_b_next        = winner ? b1 : b0;
          grant0_next      = ~winner;
          grant1_next      = winner;
          state_next       = LOAD;
        end
      end
      LOAD: begin
        acc_next   = {{(WIDTH+1){1'b0}}, op_b};
        count_next = '0;
        state_next = TEST;
      end
      TEST: begin
        state_next = acc[0] ? ADD : SHIFT;
      end
      ADD: begin
        // The top bit is always clear here after the previous shift, so it holds the carry.
        acc_next[2*WIDTH:WIDTH] = acc[2*WIDTH:WIDTH] + {1'b0, op_a};
        state_next              = SHIFT;
      end
      SHIFT: begin
        acc_next   = acc >> 1;
        count_next = count + CW'(1);
        state_next = (count == CW'(WIDTH-1)) ? DONE : TEST;
      end
      DONE: begin
        product_next = acc[2*WIDTH-1:0];
        done0_next   = ~owner;
        done1_next   = owner;
        state_next   = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: arbitration order, latency, products, operand
// capture, back-to-back throughput and mid-operation reset.
module tb_mult_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [3:0] a0, b0, a1, b1;
  logic       grant0, grant1, done0, done1;
  logic [7:0] product;
  logic       busy;

  int compared   = 0;
  int mismatched = 0;
  int cycles;

  mult_arbiter #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req0    (req0),
    .a0      (a0),
    .b0      (b0),
    .req1    (req1),
    .a1      (a1),
    .b1      (b1),
    .grant0  (grant0),
    .grant1  (grant1),
    .done0   (done0),
    .done1   (done1),
    .product (product),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic [3:0] x0, input logic [3:0] y0,
                               input logic r1, input logic [3:0] x1, input logic [3:0] y1);
    req0 = r0; a0 = x0; b0 = y0;
    req1 = r1; a1 = x1; b1 = y1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Returns the number of negedges until a grant is seen and checks which one fired.
  task automatic waitGrant(input int exp_owner, input string tag, output int n);
    n = 21;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (grant0 || grant1) begin
        n = i;
        break;
      end
    end
    checkOutput({tag, "_grant0"}, {31'd0, grant0}, (exp_owner == 0) ? 32'd1 : 32'd0);
    checkOutput({tag, "_grant1"}, {31'd0, grant1}, (exp_owner == 1) ? 32'd1 : 32'd0);
    checkOutput({tag, "_busy_at_grant"}, {31'd0, busy}, 32'd1);
  endtask

  // Called on the negedge where grant is visible; counts cycles until done.
  task automatic waitDone(input int exp_owner, input int exp_lat, input int exp_prod, input string tag);
    int n;
    n = 41;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done0 || done1) begin
        n = i;
        break;
      end
    end
    checkOutput({tag, "_latency"}, n, exp_lat);
    checkOutput({tag, "_done0"}, {31'd0, done0}, (exp_owner == 0) ? 32'd1 : 32'd0);
    checkOutput({tag, "_done1"}, {31'd0, done1}, (exp_owner == 1) ? 32'd1 : 32'd0);
    checkOutput({tag, "_product"}, {24'd0, product}, exp_prod);
    checkOutput({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);

    // Reset state
    doReset();
    checkOutput("reset_grant0", {31'd0, grant0}, 32'd0);
    checkOutput("reset_grant1", {31'd0, grant1}, 32'd0);
    checkOutput("reset_done0", {31'd0, done0}, 32'd0);
    checkOutput("reset_done1", {31'd0, done1}, 32'd0);
    checkOutput("reset_product", {24'd0, product}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);

    // Single request 7*5
    applyStimulus(1'b1, 4'd7, 4'd5, 1'b0, 4'd0, 4'd0);
    waitGrant(0, "t1", cycles);
    checkOutput("t1_grant_delay", cycles, 32'd1);
    req0 = 1'b0;
    waitDone(0, 12, 35, "t1");
    @(negedge clk);
    checkOutput("t1_done_one_cycle", {31'd0, done0}, 32'd0);
    checkOutput("t1_product_held", {24'd0, product}, 32'd35);

    // Simultaneous requests after reset: requester 0 first
    doReset();
    applyStimulus(1'b1, 4'd15, 4'd15, 1'b1, 4'd3, 4'd0);
    waitGrant(0, "t2a", cycles);
    req0 = 1'b0;
    waitDone(0, 14, 225, "t2a");
    waitGrant(1, "t2b", cycles);
    checkOutput("t2b_no_bubble", cycles, 32'd1);
    req1 = 1'b0;
    waitDone(1, 10, 0, "t2b");

    // Both held: alternate 0,1,0,1 with no idle cycles
    doReset();
    applyStimulus(1'b1, 4'd2, 4'd3, 1'b1, 4'd4, 4'd1);
    waitGrant(0, "t3a", cycles);
    waitDone(0, 12, 6, "t3a");
    waitGrant(1, "t3b", cycles);
    checkOutput("t3b_no_bubble", cycles, 32'd1);
    waitDone(1, 11, 4, "t3b");
    waitGrant(0, "t3c", cycles);
    checkOutput("t3c_no_bubble", cycles, 32'd1);
    waitDone(0, 12, 6, "t3c");
    waitGrant(1, "t3d", cycles);
    checkOutput("t3d_no_bubble", cycles, 32'd1);
    applyStimulus(1'b0, 4'd2, 4'd3, 1'b0, 4'd4, 4'd1);
    waitDone(1, 11, 4, "t3d");

    // Operands change right after grant: captured 9*6 must be used
    applyStimulus(1'b1, 4'd9, 4'd6, 1'b0, 4'd0, 4'd0);
    waitGrant(0, "t4", cycles);
    applyStimulus(1'b0, 4'd15, 4'd15, 1'b0, 4'd0, 4'd0);
    waitDone(0, 12, 54, "t4");

    // Boundaries
    applyStimulus(1'b1, 4'd0, 4'd15, 1'b0, 4'd0, 4'd0);
    waitGrant(0, "t5a", cycles);
    req0 = 1'b0;
    waitDone(0, 14, 0, "t5a");
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 4'd15, 4'd1);
    waitGrant(1, "t5b", cycles);
    req1 = 1'b0;
    waitDone(1, 11, 15, "t5b");
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 4'd15, 4'd15);
    waitGrant(1, "t5c", cycles);
    req1 = 1'b0;
    waitDone(1, 14, 225, "t5c");

    // Reset in the 5th cycle of an operation aborts it
    applyStimulus(1'b1, 4'd7, 4'd5, 1'b0, 4'd0, 4'd0);
    waitGrant(0, "t6", cycles);
    req0 = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("t6_busy_after_rst", {31'd0, busy}, 32'd0);
    checkOutput("t6_product_after_rst", {24'd0, product}, 32'd0);
    checkOutput("t6_done0_after_rst", {31'd0, done0}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checkOutput("t6_no_late_done", {31'd0, done0 | done1}, 32'd0);
    end
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 4'd6, 4'd7);
    waitGrant(1, "t6r", cycles);
    req1 = 1'b0;
    waitDone(1, 13, 42, "t6r");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
